bram_req_adapter: RTL and testbench

BRAM_REQ_ADAPTER -- requirements
Module: bram_req_adapter

---
 rtl/bram_req_adapter.sv | 103 ++++++++++
 tb/tb_bram_req_adapter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_req_adapter.sv
// Request/response adapter in front of a single-port write-first BRAM with credit-based read flow control.
// Define BRAM_REQ_ADAPTER_PIPELINED_EN for a BRAM with an output register (read latency 2 instead of 1).
module bram_req_adapter #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int RESP_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_data,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  bram_en,
   output logic                  bram_we,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [DATA_WIDTH-1:0] bram_di,
   input  logic [DATA_WIDTH-1:0] bram_do
);

`ifdef BRAM_REQ_ADAPTER_PIPELINED_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam int PTR_W = $clog2(RESP_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic                  fire;
   logic                  rd_fire;
   logic                  push;
   logic                  pop;
   logic [LAT-1:0]        vld_pipe;
   logic [CNT_W-1:0]      inflight;
   logic [CNT_W:0]        credits_used;
   logic [CNT_W-1:0]      fifo_count;
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [DATA_WIDTH-1:0] mem [RESP_DEPTH];

   assign fire      = req_valid & req_ready;
   assign rd_fire   = fire & ~req_write;
   assign bram_en   = fire;
   assign bram_we   = fire & req_write;
   assign bram_addr = req_addr;
   assign bram_di   = req_data;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < LAT; i++) inflight = inflight + CNT_W'(vld_pipe[i]);
   end

   // Every read holds a FIFO slot from issue until pop, so the FIFO can never overflow.
   // Only registered state feeds this: a same-cycle pop frees its slot one cycle later.
   assign credits_used = {1'b0, fifo_count} + {1'b0, inflight};
   assign req_ready    = credits_used < (CNT_W+1)'(RESP_DEPTH);

   assign push       = vld_pipe[LAT-1];
   assign resp_valid = (fifo_count != '0);
   assign pop        = resp_valid & resp_ready;
   assign resp_data  = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= rd_fire;
         for (int i = 1; i < LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_count <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Response storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bram_do;
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (rst_n) assert (!(push && !pop && fifo_count == CNT_W'(RESP_DEPTH)));
   end
`endif

endmodule

// File: tb/tb_bram_req_adapter.sv
// Directed bench for bram_req_adapter with a write-first BRAM model of matching latency
// (BRAM_REQ_ADAPTER_PIPELINED_EN selects latency 2).
module tb_bram_req_adapter;
`ifdef BRAM_REQ_ADAPTER_PIPELINED_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [9:0]  req_addr = '0;
   logic [31:0] req_data = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_data;
   logic        bram_en, bram_we;
   logic [9:0]  bram_addr;
   logic [31:0] bram_di, bram_do;
   logic [31:0] do1, do2;
   logic [31:0] bmem [0:1023];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   bram_req_adapter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RESP_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_data(req_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_di(bram_di), .bram_do(bram_do)
   );

   // write-first BRAM, optional output register
   always @(posedge clk) begin
      if (bram_en) begin
         if (bram_we) begin
            bmem[bram_addr] <= bram_di;
            do1 <= bram_di;
         end else begin
            do1 <= bmem[bram_addr];
         end
      end
      do2 <= do1;
   end
   assign bram_do = (LAT == 2) ? do2 : do1;

   function automatic logic [31:0] expv(input int a);
      return 32'(32'h5A00_0000 + a * 257);
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_reads(input int base, input int n, output int acc);
      acc = 0;
      for (int c = 0; c < 20 && acc < n; c++) begin
         req_valid = 1'b1;
         req_write = 1'b0;
         req_addr  = 10'(base + acc);
         @(negedge clk);
         if (req_ready) acc++;
         cyc();
      end
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
      tests++; if ({bram_en, bram_we} !== 2'b00) begin fails++; $display("FAIL reset_bram_en_we: got %b want 00", {bram_en, bram_we}); end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
      tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL post_reset_resp_valid: got %b want 0", resp_valid); end
      cyc();
   endtask

   task automatic test_write_read();
      req_valid = 1'b1; req_write = 1'b1; req_addr = 10'h005; req_data = 32'hDEADBEEF;
      @(negedge clk);
      tests++; if ({bram_en, bram_we} !== 2'b11) begin fails++; $display("FAIL wr_en_we: got %b want 11", {bram_en, bram_we}); end
      tests++; if (bram_addr !== 10'h005 || bram_di !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_addr_di: got %h/%h want 005/deadbeef", bram_addr, bram_di); end
      cyc();
      req_write = 1'b0; req_data = 32'h0;
      @(negedge clk);
      tests++; if ({bram_en, bram_we} !== 2'b10) begin fails++; $display("FAIL rd_en_we: got %b want 10", {bram_en, bram_we}); end
      cyc();
      req_valid = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rd_early_resp: got %b want 0 at t+%0d", resp_valid, k); end
         cyc();
      end
      @(negedge clk);
      tests++; if (resp_valid !== 1'b1) begin fails++; $display("FAIL rd_resp_valid: got %b want 1", resp_valid); end
      tests++; if (resp_data !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_resp_data: got %h want deadbeef", resp_data); end
      cyc();
      @(negedge clk);
      tests++; if (resp_valid !== 1'b1 || resp_data !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_hold: got %b/%h want 1/deadbeef", resp_valid, resp_data); end
      resp_ready = 1'b1;
      cyc();
      resp_ready = 1'b0;
      @(negedge clk);
      tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rd_pop_empty: got %b want 0", resp_valid); end
      cyc();
   endtask

   task automatic test_preload();
      for (int i = 0; i < 16; i++) begin
         req_valid = 1'b1; req_write = 1'b1; req_addr = 10'(16 + i); req_data = expv(16 + i);
         @(negedge clk);
         tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL preload_ready: got %b want 1 at %0d", req_ready, i); end
         cyc();
      end
      req_valid = 1'b0; req_write = 1'b0;
      repeat (LAT + 2) begin
         @(negedge clk);
         tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL write_no_resp: got %b want 0", resp_valid); end
         cyc();
      end
   endtask

   task automatic test_credit();
      int acc = 0;
      int got = 0;
      resp_ready = 1'b0;
      for (int c = 0; c < 12; c++) begin
         req_valid = (acc < 6); req_write = 1'b0; req_addr = 10'(16 + acc);
         @(negedge clk);
         if (req_valid && req_ready) acc++;
         cyc();
      end
      tests++; if (acc !== 4) begin fails++; $display("FAIL credit_accepted: got %0d want 4", acc); end
      @(negedge clk);
      tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL credit_ready_low: got %b want 0", req_ready); end
      cyc();
      resp_ready = 1'b1;
      for (int c = 0; c < 40 && (got < 6 || acc < 6); c++) begin
         req_valid = (acc < 6); req_addr = 10'(16 + acc);
         @(negedge clk);
         if (resp_valid) begin
            tests++; if (resp_data !== expv(16 + got)) begin fails++; $display("FAIL credit_order: got %h want %h (#%0d)", resp_data, expv(16 + got), got); end
            got++;
         end
         if (req_valid && req_ready) acc++;
         cyc();
      end
      req_valid = 1'b0; resp_ready = 1'b0;
      tests++; if (got !== 6 || acc !== 6) begin fails++; $display("FAIL credit_drain: got %0d resp/%0d acc want 6/6", got, acc); end
      cyc();
   endtask

   task automatic test_back_to_back();
      int acc = 0;
      int got = 0;
      int first_resp = -1;
      resp_ready = 1'b1;
      for (int c = 0; c < 60 && got < 16; c++) begin
         req_valid = (acc < 16); req_write = 1'b0; req_addr = 10'(16 + acc);
         @(negedge clk);
         if (req_valid) begin
            tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready: got %b want 1 at cycle %0d", req_ready, c); end
         end
         if (resp_valid) begin
            if (first_resp < 0) first_resp = c;
            tests++; if (resp_data !== expv(16 + got) || c != first_resp + got) begin
               fails++; $display("FAIL b2b_resp: got %h at cycle %0d want %h at cycle %0d", resp_data, c, expv(16 + got), first_resp + got);
            end
            got++;
         end
         if (req_valid && req_ready) acc++;
         cyc();
      end
      req_valid = 1'b0; resp_ready = 1'b0;
      tests++; if (got !== 16) begin fails++; $display("FAIL b2b_count: got %0d want 16", got); end
      tests++; if (first_resp !== LAT + 1) begin fails++; $display("FAIL b2b_latency: got %0d want %0d", first_resp, LAT + 1); end
      cyc();
   endtask

   task automatic test_full_pop();
      int acc;
      int got = 0;
      resp_ready = 1'b0;
      issue_reads(16'h18, 4, acc);
      tests++; if (acc !== 4) begin fails++; $display("FAIL full_fill: got %0d want 4", acc); end
      repeat (LAT + 1) cyc();
      req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h01C; resp_ready = 1'b1;
      @(negedge clk);
      tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL full_pop_ready: got %b want 0", req_ready); end
      tests++; if (resp_valid !== 1'b1 || resp_data !== expv(16'h18)) begin fails++; $display("FAIL full_head: got %b/%h want 1/%h", resp_valid, resp_data, expv(16'h18)); end
      cyc();
      resp_ready = 1'b0;
      @(negedge clk);
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL full_ready_next: got %b want 1", req_ready); end
      cyc();
      req_valid = 1'b0;
      resp_ready = 1'b1;
      for (int c = 0; c < 20 && got < 4; c++) begin
         @(negedge clk);
         if (resp_valid) begin
            tests++; if (resp_data !== expv(16'h19 + got)) begin fails++; $display("FAIL full_order: got %h want %h", resp_data, expv(16'h19 + got)); end
            got++;
         end
         cyc();
      end
      resp_ready = 1'b0;
      tests++; if (got !== 4) begin fails++; $display("FAIL full_drain: got %0d want 4", got); end
      cyc();
   endtask

   task automatic test_reset_inflight();
      int acc;
      int acc2;
      resp_ready = 1'b0;
      issue_reads(16'h10, 4 - LAT, acc);
      repeat (LAT + 1) cyc();
      issue_reads(16'h14, LAT, acc2);
      tests++; if (acc + acc2 !== 4) begin fails++; $display("FAIL rst_setup: got %0d want 4", acc + acc2); end
      tests++; if (resp_valid !== 1'b1) begin fails++; $display("FAIL rst_pre_valid: got %b want 1", resp_valid); end
      #2 rst_n = 1'b0;
      #1;
      tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rst_async_valid: got %b want 0", resp_valid); end
      tests++; if (bram_en !== 1'b0) begin fails++; $display("FAIL rst_async_en: got %b want 0", bram_en); end
      cyc(); cyc();
      rst_n = 1'b1;
      @(negedge clk);
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_rel_ready: got %b want 1", req_ready); end
      cyc();
      repeat (LAT + 3) begin
         @(negedge clk);
         tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rst_stale_resp: got %b want 0", resp_valid); end
         cyc();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write_read();
      test_preload();
      test_credit();
      test_back_to_back();
      test_full_pop();
      test_reset_inflight();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
